// File: rtl/maxpool_pkg.sv
// Shared types and constants for the 3x3 max-pool frame scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package maxpool_pkg;

    // Scheduler states, one per phase of a frame.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_VSYNC = 3'd1,
        S_WAIT  = 3'd2,
        S_SYNC  = 3'd3,
        S_RUN   = 3'd4,
        S_GAP   = 3'd5,
        S_DRAIN = 3'd6
    } state_t;

    // Default counter / configuration widths.
    localparam int W_BITS_DEF = 9;
    localparam int H_BITS_DEF = 9;
    localparam int C_BITS_DEF = 8;

    // Bit positions inside the 3-bit vertical row mask.
    localparam int MSK_UP  = 2;   // row-1
    localparam int MSK_MID = 1;   // centre row
    localparam int MSK_DN  = 0;   // row+1

    // Builds the vertical pad mask for a centre row: outer rows are
    // masked off at the top and bottom edges of the frame.
    function automatic logic [2:0] row_mask(input logic first_row, input logic last_row);
        logic [2:0] m;
        m          = '0;
        m[MSK_UP]  = ~first_row;
        m[MSK_MID] = 1'b1;
        m[MSK_DN]  = ~last_row;
        return m;
    endfunction

endpackage

// File: rtl/maxpool_scan_cnt.sv
// Nested column / channel / row counter for the max-pool frame walk.
// Latency: counters update on the clock edge after a step request.
// Backpressure: none; steps only when the scheduler asks.
module maxpool_scan_cnt
    import maxpool_pkg::*;
#(
    parameter int W_BITS = W_BITS_DEF,
    parameter int H_BITS = H_BITS_DEF,
    parameter int C_BITS = C_BITS_DEF
) (
    input  logic              i_sclk,
    input  logic              i_rst,
    input  logic              clr,
    input  logic              col_inc,
    input  logic              seg_adv,
    input  logic [W_BITS-1:0] cfg_w,
    input  logic [H_BITS-1:0] cfg_h,
    input  logic [C_BITS-1:0] cfg_c,
    output logic [W_BITS-1:0] col,
    output logic [C_BITS-1:0] ch,
    output logic [H_BITS-1:0] row,
    output logic              last_col,
    output logic              last_ch,
    output logic              last_row
);

    // Configured sizes are already clamped to >=1, so size-1 never wraps.
    assign last_col = (col == cfg_w - W_BITS'(1));
    assign last_ch  = (ch  == cfg_c - C_BITS'(1));
    assign last_row = (row == cfg_h - H_BITS'(1));

    // Column steps inside a segment; a segment advance moves channel, then row.
    always_ff @(posedge i_sclk or posedge i_rst) begin
        if (i_rst) begin
            col <= '0;
            ch  <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            ch  <= '0;
            row <= '0;
        end else if (seg_adv) begin
            col <= '0;
            if (last_ch) begin
                ch  <= '0;
                row <= last_row ? '0 : row + H_BITS'(1);
            end else begin
                ch  <= ch + C_BITS'(1);
            end
        end else if (col_inc) begin
            col <= col + W_BITS'(1);
        end
    end

endmodule

// File: rtl/maxpool_scan_ctrl.sv
// Frame scheduler for the 3x3 max-pool datapath; optional stride-2 keep decimation via MAXPOOL_STRIDE2_EN.
// Latency: segment = sync + W columns + pad column + GAP idle; o_done DP_LAT+1 cycles after the last column strobe.
// Backpressure: i_ready is sampled only before a segment starts; a started segment never stalls.
module maxpool_scan_ctrl
    import maxpool_pkg::*;
#(
    parameter int W_BITS = W_BITS_DEF,
    parameter int H_BITS = H_BITS_DEF,
    parameter int C_BITS = C_BITS_DEF,
    parameter int GAP    = 2,
    parameter int DP_LAT = 4
) (
    input  logic              i_sclk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [W_BITS-1:0] i_cfg_w,
    input  logic [H_BITS-1:0] i_cfg_h,
    input  logic [C_BITS-1:0] i_cfg_c,
    input  logic              i_ready,
    output logic              o_vsync,
    output logic              o_hsync,
    output logic              o_reuse,
    output logic              o_valid,
    output logic [W_BITS-1:0] o_rd_col,
    output logic [C_BITS-1:0] o_rd_ch,
    output logic [H_BITS-1:0] o_rd_row,
    output logic [2:0]        o_row_msk,
    output logic              o_pad_col,
    output logic              o_keep,
    output logic              o_busy,
    output logic              o_done
);

    localparam int              DR_BITS    = $clog2(DP_LAT + 2);
    localparam logic [3:0]      GAP_LAST   = 4'(GAP - 1);
    localparam logic [DR_BITS-1:0] DRAIN_LAST = DR_BITS'(DP_LAT);

    state_t              state;
    state_t              nxt;

    logic [W_BITS-1:0]   cfg_w_q;
    logic [H_BITS-1:0]   cfg_h_q;
    logic [C_BITS-1:0]   cfg_c_q;

    logic                pad_q;
    logic [3:0]          gap_cnt;
    logic [DR_BITS-1:0]  drain_cnt;

    logic                cnt_clr;
    logic                col_inc;
    logic                seg_adv;
    logic                pad_set;

    logic [W_BITS-1:0]   col;
    logic [C_BITS-1:0]   ch;
    logic [H_BITS-1:0]   row;
    logic                last_col;
    logic                last_ch;
    logic                last_row;

    logic                rd_en;
    logic                keep_dec;

    maxpool_scan_cnt #(
        .W_BITS (W_BITS),
        .H_BITS (H_BITS),
        .C_BITS (C_BITS)
    ) u_cnt (
        .i_sclk   (i_sclk),
        .i_rst    (i_rst),
        .clr      (cnt_clr),
        .col_inc  (col_inc),
        .seg_adv  (seg_adv),
        .cfg_w    (cfg_w_q),
        .cfg_h    (cfg_h_q),
        .cfg_c    (cfg_c_q),
        .col      (col),
        .ch       (ch),
        .row      (row),
        .last_col (last_col),
        .last_ch  (last_ch),
        .last_row (last_row)
    );

    // State register.
    always_ff @(posedge i_sclk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Configuration is captured once per frame; a size of 0 behaves as 1.
    always_ff @(posedge i_sclk or posedge i_rst) begin
        if (i_rst) begin
            cfg_w_q <= '0;
            cfg_h_q <= '0;
            cfg_c_q <= '0;
        end else if (state == S_IDLE && i_start) begin
            cfg_w_q <= (i_cfg_w == '0) ? W_BITS'(1) : i_cfg_w;
            cfg_h_q <= (i_cfg_h == '0) ? H_BITS'(1) : i_cfg_h;
            cfg_c_q <= (i_cfg_c == '0) ? C_BITS'(1) : i_cfg_c;
        end
    end

    // Pad-column flag: set after the last real column, cleared at each new segment.
    always_ff @(posedge i_sclk or posedge i_rst) begin
        if (i_rst) begin
            pad_q <= 1'b0;
        end else if (cnt_clr || seg_adv) begin
            pad_q <= 1'b0;
        end else if (pad_set) begin
            pad_q <= 1'b1;
        end
    end

    // Idle-gap and drain timers run only while in their own state.
    always_ff @(posedge i_sclk or posedge i_rst) begin
        if (i_rst) begin
            gap_cnt   <= '0;
            drain_cnt <= '0;
        end else begin
            gap_cnt   <= (state == S_GAP)   ? gap_cnt + 4'd1           : 4'd0;
            drain_cnt <= (state == S_DRAIN) ? drain_cnt + DR_BITS'(1)  : '0;
        end
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        nxt     = state;
        cnt_clr = 1'b0;
        col_inc = 1'b0;
        seg_adv = 1'b0;
        pad_set = 1'b0;
        o_vsync = 1'b0;
        o_hsync = 1'b0;
        o_reuse = 1'b0;
        o_valid = 1'b0;
        o_done  = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    cnt_clr = 1'b1;
                    nxt     = S_VSYNC;
                end
            end
            S_VSYNC: begin
                o_vsync = 1'b1;
                nxt     = S_WAIT;
            end
            S_WAIT: begin
                if (i_ready) begin
                    nxt = S_SYNC;
                end
            end
            S_SYNC: begin
                o_hsync = (ch == '0);
                o_reuse = (ch != '0);
                nxt     = S_RUN;
            end
            S_RUN: begin
                o_valid = 1'b1;
                if (!pad_q) begin
                    if (last_col) begin
                        pad_set = 1'b1;
                    end else begin
                        col_inc = 1'b1;
                    end
                end else if (last_ch && last_row) begin
                    // No gap after the final segment: the drain timer starts right away.
                    nxt = S_DRAIN;
                end else if (GAP == 0) begin
                    seg_adv = 1'b1;
                    nxt     = S_WAIT;
                end else begin
                    nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    seg_adv = 1'b1;
                    nxt     = S_WAIT;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    o_done = 1'b1;
                    nxt    = S_IDLE;
                end
            end
            default: begin
                nxt = S_IDLE;
            end
        endcase
    end

`ifdef MAXPOOL_STRIDE2_EN
    // RUN cycle k carries centre column k-1; keep only even centres on even rows.
    // k is odd exactly when the column counter (or W, on the pad cycle) is odd.
    assign keep_dec = (pad_q ? cfg_w_q[0] : col[0]) & ~row[0];
`else
    assign keep_dec = 1'b1;
`endif

    // Line-buffer read controls are presented from segment sync through the pad column.
    always_comb begin
        rd_en     = (state == S_SYNC) || (state == S_RUN);
        o_rd_col  = rd_en ? col : '0;
        o_rd_ch   = rd_en ? ch  : '0;
        o_rd_row  = rd_en ? row : '0;
        o_row_msk = rd_en ? row_mask(row == '0, last_row) : 3'b000;
        o_pad_col = (state == S_RUN) && pad_q;
        o_keep    = (state == S_RUN) && (pad_q || col != '0) && keep_dec;
    end

    assign o_busy = (state != S_IDLE);

endmodule

// File: tb/tb_maxpool_scan_ctrl.sv
module tb_maxpool_scan_ctrl;

    localparam int W_BITS = 9;
    localparam int H_BITS = 9;
    localparam int C_BITS = 8;
    localparam int GAP    = 2;
    localparam int DP_LAT = 4;

    localparam int K_VS = 16;
    localparam int K_HS = 8;
    localparam int K_RE = 4;
    localparam int K_VA = 2;
    localparam int K_DN = 1;

    logic              i_sclk = 1'b0;
    logic              i_rst  = 1'b1;
    logic              i_start = 1'b0;
    logic [W_BITS-1:0] i_cfg_w = '0;
    logic [H_BITS-1:0] i_cfg_h = '0;
    logic [C_BITS-1:0] i_cfg_c = '0;
    logic              i_ready = 1'b1;
    logic              o_vsync, o_hsync, o_reuse, o_valid;
    logic [W_BITS-1:0] o_rd_col;
    logic [C_BITS-1:0] o_rd_ch;
    logic [H_BITS-1:0] o_rd_row;
    logic [2:0]        o_row_msk;
    logic              o_pad_col, o_keep, o_busy, o_done;

    always #5 i_sclk = ~i_sclk;

    maxpool_scan_ctrl #(
        .W_BITS (W_BITS),
        .H_BITS (H_BITS),
        .C_BITS (C_BITS),
        .GAP    (GAP),
        .DP_LAT (DP_LAT)
    ) dut (
        .i_sclk    (i_sclk),
        .i_rst     (i_rst),
        .i_start   (i_start),
        .i_cfg_w   (i_cfg_w),
        .i_cfg_h   (i_cfg_h),
        .i_cfg_c   (i_cfg_c),
        .i_ready   (i_ready),
        .o_vsync   (o_vsync),
        .o_hsync   (o_hsync),
        .o_reuse   (o_reuse),
        .o_valid   (o_valid),
        .o_rd_col  (o_rd_col),
        .o_rd_ch   (o_rd_ch),
        .o_rd_row  (o_rd_row),
        .o_row_msk (o_row_msk),
        .o_pad_col (o_pad_col),
        .o_keep    (o_keep),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    typedef struct {
        int kind;
        int col;
        int ch;
        int row;
        int msk;
        int pad;
        int keep;
        int rel;   // cycles since previous output event, -1 = any
    } ev_t;

    ev_t exp_q[$];
    int  n_vec    = 0;
    int  n_err    = 0;
    int  cyc      = 0;
    int  last_evt = -1;
    int  kept_cnt = 0;
    int  exp_keeps = 0;

    function automatic ev_t mk(input int kind, col, ch, row, msk, pad, keep, rel);
        ev_t e;
        e.kind = kind; e.col = col; e.ch = ch; e.row = row;
        e.msk = msk; e.pad = pad; e.keep = keep; e.rel = rel;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Expected event stream of one frame, derived from the frame geometry.
    task automatic push_frame(input int w, input int h, input int c, output int keeps);
        int ww, hh, cc;
        ww = (w == 0) ? 1 : w;
        hh = (h == 0) ? 1 : h;
        cc = (c == 0) ? 1 : c;
        keeps = 0;
        exp_q.push_back(mk(K_VS, 0, 0, 0, 0, 0, 0, -1));
        for (int r = 0; r < hh; r++) begin
            for (int ch = 0; ch < cc; ch++) begin
                int msk;
                msk = ((r != 0) ? 4 : 0) | 2 | ((r != hh - 1) ? 1 : 0);
                exp_q.push_back(mk((ch == 0) ? K_HS : K_RE, 0, ch, r, msk, 0, 0, -1));
                for (int k = 0; k <= ww; k++) begin
                    int kp;
                    kp = (k >= 1) ? 1 : 0;
`ifdef MAXPOOL_STRIDE2_EN
                    if (((k - 1) % 2) != 0 || (r % 2) != 0) kp = 0;
`endif
                    keeps += kp;
                    exp_q.push_back(mk(K_VA, (k < ww) ? k : ww - 1, ch, r, msk,
                                       (k == ww) ? 1 : 0, kp, 1));
                end
            end
        end
        exp_q.push_back(mk(K_DN, 0, 0, 0, 0, 0, 0, DP_LAT + 1));
    endtask

    // Monitor: every cycle with a strobe is one observed event, checked in order.
    always @(negedge i_sclk) begin
        int  kind;
        int  rel;
        ev_t e;
        cyc++;
        kind = int'({o_vsync, o_hsync, o_reuse, o_valid, o_done});
        if (kind != 0) begin
            rel = (last_evt < 0) ? -1 : cyc - last_evt;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event: got kind=%0d col=%0d ch=%0d row=%0d, expected none",
                         kind, o_rd_col, o_rd_ch, o_rd_row);
            end else begin
                e = exp_q.pop_front();
                if (kind != e.kind || int'(o_rd_col) != e.col || int'(o_rd_ch) != e.ch ||
                    int'(o_rd_row) != e.row || int'(o_row_msk) != e.msk ||
                    int'(o_pad_col) != e.pad || int'(o_keep) != e.keep ||
                    (e.rel >= 0 && rel != e.rel)) begin
                    n_err++;
                    $display("FAIL event: got kind=%0d col=%0d ch=%0d row=%0d msk=%b pad=%0d keep=%0d rel=%0d; expected kind=%0d col=%0d ch=%0d row=%0d msk=%0d pad=%0d keep=%0d rel=%0d",
                             kind, o_rd_col, o_rd_ch, o_rd_row, o_row_msk, o_pad_col, o_keep, rel,
                             e.kind, e.col, e.ch, e.row, e.msk, e.pad, e.keep, e.rel);
                end
            end
            if (o_keep) kept_cnt++;
            last_evt = cyc;
        end
    end

    task automatic start_frame(input int w, input int h, input int c);
        push_frame(w, h, c, exp_keeps);
        kept_cnt = 0;
        i_cfg_w = W_BITS'(w);
        i_cfg_h = H_BITS'(h);
        i_cfg_c = C_BITS'(c);
        @(posedge i_sclk); #1;
        i_start = 1'b1;
        @(posedge i_sclk); #1;
        i_start = 1'b0;
        // Scramble the inputs: the frame must run on the captured configuration.
        i_cfg_w = W_BITS'(7);
        i_cfg_h = H_BITS'(7);
        i_cfg_c = C_BITS'(7);
        @(negedge i_sclk);
        chk("busy_after_start", 64'(o_busy), 64'(1));
    endtask

    task automatic finish_frame(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge i_sclk);
            if (o_done) seen = 1'b1;
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_done_timeout: got no o_done, expected o_done within 3000 cycles", nm);
        end else begin
            chk({nm, "_busy_at_done"}, 64'(o_busy), 64'(1));
            @(negedge i_sclk);
            chk({nm, "_busy_after_done"}, 64'(o_busy), 64'(0));
            chk({nm, "_done_width"}, 64'(o_done), 64'(0));
        end
        chk({nm, "_keep_count"}, 64'(kept_cnt), 64'(exp_keeps));
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({o_vsync, o_hsync, o_reuse, o_valid, o_rd_col, o_rd_ch, o_rd_row,
                    o_row_msk, o_pad_col, o_keep, o_busy, o_done});
    endfunction

    initial begin
        bit hit;

        // Reset state.
        repeat (3) @(posedge i_sclk);
        @(negedge i_sclk);
        chk("reset_outputs", all_outs(), 64'(0));
        @(posedge i_sclk); #1;
        i_rst = 1'b0;
        @(negedge i_sclk);
        chk("idle_outputs", all_outs(), 64'(0));

        // Frame A: single channel, three rows.
        start_frame(4, 3, 1);
        finish_frame("w4h3c1");

        // Frame B: three channels; a stray start mid-frame must be ignored.
        start_frame(3, 2, 3);
        repeat (10) @(posedge i_sclk);
        #1 i_start = 1'b1;
        @(posedge i_sclk); #1 i_start = 1'b0;
        finish_frame("w3h2c3");

        // Frame C: i_ready dropped during row 0's RUN and held low while it waits.
        start_frame(4, 3, 1);
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge i_sclk);
            if (o_hsync) hit = 1'b1;
        end
        chk("ready_test_hsync_seen", 64'(hit), 64'(1));
        @(posedge i_sclk); #1 i_ready = 1'b0;
        repeat (10) @(negedge i_sclk);
        for (int i = 0; i < 10; i++) begin
            @(negedge i_sclk);
            chk("wait_no_strobes", 64'({o_vsync, o_hsync, o_reuse, o_valid, o_busy}), 64'(1));
        end
        @(posedge i_sclk); #1 i_ready = 1'b1;
        finish_frame("ready_stall");

        // Frame D: asynchronous reset in the middle of a row.
        start_frame(8, 2, 1);
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge i_sclk);
            if (o_valid && o_rd_col == W_BITS'(3)) hit = 1'b1;
        end
        chk("midrun_col3_seen", 64'(hit), 64'(1));
        @(posedge i_sclk); #2;
        i_rst = 1'b1;
        #1;
        chk("async_reset_outputs", all_outs(), 64'(0));
        exp_q.delete();
        last_evt = -1;
        repeat (2) @(posedge i_sclk);
        #1 i_rst = 1'b0;
        @(negedge i_sclk);
        chk("post_reset_idle", all_outs(), 64'(0));
        start_frame(8, 2, 1);
        finish_frame("after_reset");

        // Frame E: 5x5 (stride-2 decimation visible when enabled).
        start_frame(5, 5, 1);
        finish_frame("w5h5c1");

        // Frame F: 1x1 frame, mask 010.
        start_frame(1, 1, 1);
        finish_frame("w1h1c1");

        // Frame G: zero channel count behaves as one channel.
        start_frame(2, 1, 0);
        finish_frame("w2h1c0");

        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
